// File: rtl/ultrasonic_ranger_if.sv
// Sensor-side bundle of the ultrasonic ranger: echo/trig pins plus the distance
// result bus that feeds the beeper stage.
interface ultrasonic_ranger_if #(
  parameter int DST_W = 12
);
  logic             echo;
  logic             trig;
  logic [DST_W-1:0] binary_dst;
  logic             dst_valid;
  logic             no_echo;

  modport master (
    input  echo,
    output trig,
    output binary_dst,
    output dst_valid,
    output no_echo
  );

  modport slave (
    output echo,
    input  trig,
    input  binary_dst,
    input  dst_valid,
    input  no_echo
  );
endinterface

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo timing, direct conversion to mm.
//   state  | meaning
//   S_IDLE | waiting for the period boundary, echo ignored
//   S_TRIG | trigger pulse high
//   S_WAIT | waiting for echo rise, timeout running
//   S_MEAS | echo high, counting millimetres until fall or timeout
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_MM  = 291,
  parameter int TIMEOUT_CYCLES = 1250000,
  parameter int PERIOD_CYCLES  = 3000000,
  parameter int DST_W          = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  ultrasonic_ranger_if.master  bus
);

  localparam int T_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int P_W   = $clog2(PERIOD_CYCLES);
  localparam int T_W   = $clog2(T_MAX + 2);
  localparam int C_W   = $clog2(CYCLES_PER_MM + 1);

  localparam logic [P_W-1:0]   PERIOD_LAST = P_W'(PERIOD_CYCLES - 1);
  localparam logic [T_W-1:0]   TRIG_LAST   = T_W'(TRIG_CYCLES - 1);
  localparam logic [T_W-1:0]   TO_LAST     = T_W'(TIMEOUT_CYCLES - 1);
  localparam logic [C_W-1:0]   PRE_LAST    = C_W'(CYCLES_PER_MM - 1);
  localparam logic [DST_W-1:0] DST_MAX     = '1;

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS} state_t;

  state_t           state;
  logic             echo_m, echo_s, echo_d;
  logic [P_W-1:0]   period_cnt;
  logic [T_W-1:0]   tcnt;
  logic [C_W-1:0]   pre_cnt;
  logic [DST_W-1:0] mm_cnt;
  logic             trig_q, dst_valid_q, no_echo_q;
  logic [DST_W-1:0] dst_q;

  logic             rise, fall, mm_tick, timeout;
  logic [DST_W-1:0] mm_next;

  assign rise    = echo_s & ~echo_d;
  assign fall    = ~echo_s & echo_d;
  assign mm_tick = (pre_cnt == PRE_LAST);
  // >= keeps a late rise (entering S_MEAS past the limit) from counting forever
  assign timeout = (tcnt >= TO_LAST);
  // the fall cycle's own tick is folded in so the result is floor(H / CYCLES_PER_MM)
  assign mm_next = (mm_tick && (mm_cnt != DST_MAX)) ? mm_cnt + DST_W'(1) : mm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      echo_m      <= 1'b0;
      echo_s      <= 1'b0;
      echo_d      <= 1'b0;
      period_cnt  <= '0;
      tcnt        <= '0;
      pre_cnt     <= '0;
      mm_cnt      <= '0;
      trig_q      <= 1'b0;
      dst_valid_q <= 1'b0;
      no_echo_q   <= 1'b0;
      dst_q       <= DST_MAX;
    end else begin
      echo_m      <= bus.echo;
      echo_s      <= echo_m;
      echo_d      <= echo_s;
      dst_valid_q <= 1'b0;
      period_cnt  <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + P_W'(1);

      case (state)
        S_IDLE: begin
          trig_q <= 1'b0;
          if (period_cnt == '0) begin
            trig_q <= 1'b1;
            tcnt   <= '0;
            state  <= S_TRIG;
          end
        end
        S_TRIG: begin
          if (tcnt == TRIG_LAST) begin
            trig_q <= 1'b0;
            tcnt   <= '0;
            state  <= S_WAIT;
          end else begin
            tcnt <= tcnt + T_W'(1);
          end
        end
        S_WAIT: begin
          tcnt <= tcnt + T_W'(1);
          if (rise) begin
            pre_cnt <= '0;
            mm_cnt  <= '0;
            state   <= S_MEAS;
          end else if (timeout) begin
            dst_q       <= DST_MAX;
            no_echo_q   <= 1'b1;
            dst_valid_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_MEAS: begin
          tcnt    <= tcnt + T_W'(1);
          pre_cnt <= mm_tick ? '0 : pre_cnt + C_W'(1);
          mm_cnt  <= mm_next;
          if (fall) begin
            dst_q       <= mm_next;
            no_echo_q   <= 1'b0;
            dst_valid_q <= 1'b1;
            state       <= S_IDLE;
          end else if (timeout) begin
            dst_q       <= DST_MAX;
            no_echo_q   <= 1'b1;
            dst_valid_q <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.trig       = trig_q;
  assign bus.binary_dst = dst_q;
  assign bus.dst_valid  = dst_valid_q;
  assign bus.no_echo    = no_echo_q;

endmodule
